// File: rtl/remote_cmd.sv
// rtl/remote_cmd.sv - UART command link to the copter: 3-byte frame transmitter plus response-byte receiver
//
// Purpose: sends {cmd, data[15:8], data[7:0]} as three back-to-back 8N1
// bytes on TX. Independently receives 8N1 response bytes on RX.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   cmd, data    frame contents, latched when snd_cmd is accepted
//   snd_cmd      one-cycle request to send a frame (ignored while busy
//                and in the cmd_sent cycle)
//   busy         high while a frame is on the line
//   cmd_sent     one-cycle pulse when the frame completes
//   TX           serial out, idle high
//   RX           serial in, asynchronous to clk
//   resp         last good response byte
//   resp_rdy     resp holds an unread byte
//   clr_resp_rdy clears resp_rdy

module remote_cmd #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  input  logic        snd_cmd,
  output logic        busy,
  output logic        cmd_sent,
  output logic        TX,
  input  logic        RX,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  // ---------------------------------------------------------------- transmit
  typedef enum logic [1:0] {TX_IDLE, TX_CMD, TX_DHI, TX_DLO} tx_state_t;

  tx_state_t     tx_state, tx_next;
  logic [7:0]    cmd_q;
  logic [15:0]   data_q;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;      // 0 = start, 1..8 = data, 9 = stop
  logic [7:0]    tx_byte;
  logic          tx_accept, tx_bit_end, tx_byte_end;

  always_comb begin
    // The cmd_sent cycle already shows busy=0, so it must be excluded explicitly.
    tx_accept   = (tx_state == TX_IDLE) && snd_cmd && !cmd_sent;
    tx_bit_end  = (tx_state != TX_IDLE) && (tx_cnt == BIT_LAST);
    tx_byte_end = tx_bit_end && (tx_bit == 4'd9);

    case (tx_state)
      TX_DHI:  tx_byte = data_q[15:8];
      TX_DLO:  tx_byte = data_q[7:0];
      default: tx_byte = cmd_q;
    endcase

    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: if (tx_accept)   tx_next = TX_CMD;
      TX_CMD:  if (tx_byte_end) tx_next = TX_DHI;
      TX_DHI:  if (tx_byte_end) tx_next = TX_DLO;
      TX_DLO:  if (tx_byte_end) tx_next = TX_IDLE;
      default: tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= 8'h00;
      data_q   <= 16'h0000;
      tx_cnt   <= '0;
      tx_bit   <= 4'd0;
      TX       <= 1'b1;
      cmd_sent <= 1'b0;
    end else begin
      cmd_sent <= tx_byte_end && (tx_state == TX_DLO);
      if (tx_accept) begin
        cmd_q  <= cmd;
        data_q <= data;
        tx_cnt <= '0;
        tx_bit <= 4'd0;
        TX     <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_bit_end) begin
          tx_cnt <= '0;
          if (tx_byte_end) begin
            tx_bit <= 4'd0;
            // Next byte's start bit follows the stop bit with no gap.
            TX     <= (tx_state == TX_DLO);
          end else begin
            tx_bit <= tx_bit + 4'd1;
            TX     <= (tx_bit == 4'd8) ? 1'b1 : tx_byte[tx_bit[2:0]];
          end
        end else begin
          tx_cnt <= tx_cnt + CW'(1);
        end
      end
    end
  end

  assign busy = (tx_state != TX_IDLE);

  // ----------------------------------------------------------------- receive
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     rx_state, rx_next;
  logic          rx_s1, rx_s2, rx_s3;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;
  logic          rx_fall, rx_half, rx_tick, rx_start_ok, rx_done_ok;

  always_comb begin
    rx_fall     = rx_s3 && !rx_s2;
    rx_half     = (rx_cnt == HALF_LAST);
    rx_tick     = (rx_cnt == BIT_LAST);
    rx_start_ok = (rx_state == RX_START) && rx_half && !rx_s2;
    rx_done_ok  = (rx_state == RX_STOP) && rx_tick && rx_s2;

    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_half) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_tick && rx_bit == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_tick) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Synchronizer resets low so a line that is already low at release
      // cannot look like a falling edge; a 1 must be seen first.
      rx_s1    <= 1'b0;
      rx_s2    <= 1'b0;
      rx_s3    <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'h00;
      resp     <= 8'h00;
      resp_rdy <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;

      case (rx_state)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_bit <= 3'd0;
        end
        RX_START: rx_cnt <= rx_half ? '0 : rx_cnt + CW'(1);
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: rx_cnt <= rx_tick ? '0 : rx_cnt + CW'(1);
        default: rx_cnt <= '0;
      endcase

      if (rx_done_ok) resp <= rx_sh;

      // A new byte arriving wins over a simultaneous clear.
      if (rx_done_ok)                       resp_rdy <= 1'b1;
      else if (clr_resp_rdy || rx_start_ok) resp_rdy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_remote_cmd.sv
// tb/tb_remote_cmd.sv - self-checking bench for remote_cmd at BAUD_DIV=16
`timescale 1ns/1ps

module tb_remote_cmd;
  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        snd_cmd;
  logic        busy;
  logic        cmd_sent;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        clr_resp_rdy;

  int checks   = 0;
  int failures = 0;
  int sent_cnt = 0;
  int hi_cnt;
  int s0;
  logic [7:0] exp_resp;
  logic       exp_rdy;

  remote_cmd #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .data(data), .snd_cmd(snd_cmd),
    .busy(busy), .cmd_sent(cmd_sent), .TX(TX), .RX(RX),
    .resp(resp), .resp_rdy(resp_rdy), .clr_resp_rdy(clr_resp_rdy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (cmd_sent === 1'b1) sent_cnt <= sent_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends one frame and checks TX against the 30-bit 8N1 image of the frame
  // on every clock. At cycle inject_at a competing snd_cmd with cmd=FF is issued.
  task automatic run_frame(input logic [7:0] c, input logic [15:0] d,
                           input int inject_at, input string tag);
    logic       exp_bits [30];
    logic [7:0] bytes [3];
    int tx_err = 0, busy_err = 0, sent_err = 0, start_cnt;
    bytes[0] = c; bytes[1] = d[15:8]; bytes[2] = d[7:0];
    for (int by = 0; by < 3; by++)
      for (int b = 0; b < 10; b++)
        exp_bits[by*10 + b] = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : bytes[by][b-1];

    start_cnt = sent_cnt;
    @(negedge clk);
    cmd = c; data = d; snd_cmd = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 30*BD; j++) begin
      if (TX !== exp_bits[j/BD]) tx_err++;
      if (busy !== 1'b1)         busy_err++;
      if (cmd_sent !== 1'b0)     sent_err++;
      snd_cmd = (j == inject_at);
      cmd     = (j == inject_at) ? 8'hFF : 8'($urandom);
      data    = 16'($urandom);
      @(negedge clk);
    end
    chk({tag, "_tx_bits_err"}, tx_err, 0);
    chk({tag, "_busy_err"}, busy_err, 0);
    chk({tag, "_early_sent_err"}, sent_err, 0);
    chk({tag, "_end_busy"}, busy, 0);
    chk({tag, "_end_cmd_sent"}, cmd_sent, 1);
    chk({tag, "_end_tx"}, TX, 1);
    // snd_cmd coincident with cmd_sent must not start a frame.
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    chk({tag, "_coincident_snd_busy"}, busy, 0);
    chk({tag, "_sent_pulse_len"}, cmd_sent, 0);
    chk({tag, "_sent_count"}, sent_cnt - start_cnt, 1);
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic v;
    for (int i = 0; i < 10; i++) begin
      v = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      @(negedge clk);
      #($urandom_range(0, 3));
      RX = v;
      repeat (BD - 1) @(negedge clk);
    end
    @(negedge clk);
    RX = 1'b1;
  endtask

  // Receiver rules: a valid start clears resp_rdy; a good stop loads resp and sets it.
  task automatic rx_byte_checked(input logic [7:0] b, input logic stop, input string tag);
    send_rx(b, stop);
    exp_rdy = stop;
    if (stop) exp_resp = b;
    repeat (4) @(negedge clk);
    chk({tag, "_resp"}, resp, exp_resp);
    chk({tag, "_rdy"}, resp_rdy, exp_rdy);
  endtask

  initial begin
    rst = 1'b1; cmd = '0; data = '0; snd_cmd = 1'b0; RX = 1'b1; clr_resp_rdy = 1'b0;
    exp_resp = 8'h00; exp_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_sent", cmd_sent, 0);
    chk("rst_resp", resp, 8'h00);
    chk("rst_resp_rdy", resp_rdy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Directed frame with a competing request mid-frame
    run_frame(8'h05, 16'hA5C3, 100, "frame_05A5C3");

    // Receive A5, then clear
    rx_byte_checked(8'hA5, 1'b1, "rx_A5");
    clr_resp_rdy = 1'b1;
    @(negedge clk);
    clr_resp_rdy = 1'b0;
    exp_rdy = 1'b0;
    chk("clr_rdy", resp_rdy, 0);
    chk("clr_resp_held", resp, 8'hA5);

    // Glitch, then a byte with a bad stop bit
    @(negedge clk); RX = 1'b0;
    repeat (4) @(negedge clk); RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_rdy", resp_rdy, 0);
    chk("glitch_resp", resp, 8'hA5);
    rx_byte_checked(8'h3C, 1'b0, "rx_3C_badstop");

    // A valid start clears an unread resp_rdy
    rx_byte_checked(8'h81, 1'b1, "rx_81");
    fork
      send_rx(8'h5B, 1'b1);
      begin
        repeat (90) @(negedge clk);
        chk("start_clears_rdy", resp_rdy, 0);
        chk("start_keeps_resp", resp, 8'h81);
      end
    join
    exp_resp = 8'h5B; exp_rdy = 1'b1;
    repeat (4) @(negedge clk);
    chk("rx_5B_resp", resp, exp_resp);
    chk("rx_5B_rdy", resp_rdy, exp_rdy);

    // Random receive bytes
    for (int k = 0; k < 4; k++) begin
      rx_byte_checked(8'($urandom), ($urandom_range(0, 3) != 0), $sformatf("rx_rand%0d", k));
      repeat ($urandom_range(1, 20)) @(negedge clk);
    end

    // Reset in the middle of a frame
    @(negedge clk);
    cmd = 8'h77; data = 16'h1234; snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (199) @(negedge clk);
    s0 = sent_cnt;
    rst = 1'b1;
    #1;
    chk("midrst_tx", TX, 1);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_resp = 8'h00; exp_rdy = 1'b0;
    repeat (600) @(negedge clk);
    chk("midrst_no_sent", sent_cnt - s0, 0);
    chk("midrst_no_resume_busy", busy, 0);
    chk("midrst_idle_tx", TX, 1);
    run_frame(8'($urandom), 16'($urandom), -1, "frame_after_rst");

    // Full duplex with clear held across the arrival of 0A
    clr_resp_rdy = 1'b1;
    hi_cnt = 0;
    fork
      run_frame(8'($urandom), 16'($urandom), -1, "frame_duplex");
      begin
        repeat (20) @(negedge clk);
        fork
          send_rx(8'h0A, 1'b1);
          repeat (165) begin
            @(negedge clk);
            if (resp_rdy === 1'b1) hi_cnt++;
          end
        join
      end
    join
    clr_resp_rdy = 1'b0;
    exp_resp = 8'h0A; exp_rdy = 1'b0;
    chk("duplex_set_wins_cycles", hi_cnt, 1);
    chk("duplex_resp", resp, exp_resp);
    chk("duplex_rdy_after_clr", resp_rdy, exp_rdy);

    // Random frames
    for (int k = 0; k < 2; k++)
      run_frame(8'($urandom), 16'($urandom), $urandom_range(0, 479), $sformatf("frame_rand%0d", k));

    // RX already low across reset release must not start a receive
    @(negedge clk);
    rst = 1'b1; RX = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_resp = 8'h00; exp_rdy = 1'b0;
    repeat (60) @(negedge clk);
    RX = 1'b1;
    repeat (40) @(negedge clk);
    chk("low_rel_rdy", resp_rdy, exp_rdy);
    chk("low_rel_resp", resp, exp_resp);
    rx_byte_checked(8'hC6, 1'b1, "rx_after_low_rel");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
